// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: address map, read response
// codes, read FSM states and mstatus field positions.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [1:0] RRESP_OKAY    = 2'd0;
    localparam logic [1:0] RRESP_ILLEGAL = 2'd2;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with an increment enable and independent
// low/high half writes; a half write suppresses the increment for that cycle.
module csr_counter64
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wr_val,
    output logic [63:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (wr_lo) begin
            count[31:0] <= wr_val;
        end else if (wr_hi) begin
            count[63:32] <= wr_val;
        end else if (inc_en) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: one-cycle read bus, single-cycle write port, trap state
// and optional 64-bit cycle/instret counters (enabled by CSR_FILE_COUNTERS_EN).
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MISA_VAL    = 32'h40000100,
    parameter logic [31:0] MTVEC_RESET = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] csrbus_araddr,
    input  logic        csrbus_arvalid,
    output logic [31:0] csrbus_rdata,
    output logic [1:0]  csrbus_rresp,
    output logic        csrbus_rvalid,
    input  logic [11:0] csr_write_addr,
    input  logic [31:0] csr_write_val,
    input  logic        csr_write_valid,
    input  logic        instret_pulse,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret_valid,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        mie_out
);

    rd_state_t   state_q, state_d;
    logic        accept;
    logic [31:0] rdata_q, rd_data;
    logic [1:0]  rresp_q, rd_resp;
    logic [31:0] mtvec_q, mepc_q, mcause_q, mscratch_q, mstatus_val;
    logic        mie_q, mpie_q;

    function automatic logic wr_hit(input logic [11:0] a);
        return csr_write_valid && (csr_write_addr == a);
    endfunction

`ifdef CSR_FILE_COUNTERS_EN
    logic [63:0] mcycle, minstret;

    csr_counter64 u_mcycle (
        .clk    (clk),
        .reset_n(reset_n),
        .inc_en (1'b1),
        .wr_lo  (wr_hit(CSR_MCYCLE)),
        .wr_hi  (wr_hit(CSR_MCYCLEH)),
        .wr_val (csr_write_val),
        .count  (mcycle)
    );

    csr_counter64 u_minstret (
        .clk    (clk),
        .reset_n(reset_n),
        .inc_en (instret_pulse),
        .wr_lo  (wr_hit(CSR_MINSTRET)),
        .wr_hi  (wr_hit(CSR_MINSTRETH)),
        .wr_val (csr_write_val),
        .count  (minstret)
    );
`else
    logic unused_instret;
    assign unused_instret = instret_pulse;
`endif

    always_comb begin
        mstatus_val = '0;
        mstatus_val[MSTATUS_MIE] = mie_q;
        mstatus_val[MSTATUS_MPIE] = mpie_q;
        mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_data = '0;
        rd_resp = RRESP_OKAY;
        case (csrbus_araddr)
            CSR_MSTATUS:   rd_data = mstatus_val;
            CSR_MISA:      rd_data = MISA_VAL;
            CSR_MTVEC:     rd_data = mtvec_q;
            CSR_MSCRATCH:  rd_data = mscratch_q;
            CSR_MEPC:      rd_data = mepc_q;
            CSR_MCAUSE:    rd_data = mcause_q;
            CSR_MVENDORID,
            CSR_MARCHID,
            CSR_MIMPID:    rd_data = '0;
            CSR_MHARTID:   rd_data = HART_ID;
`ifdef CSR_FILE_COUNTERS_EN
            CSR_MCYCLE:    rd_data = mcycle[31:0];
            CSR_MINSTRET:  rd_data = minstret[31:0];
            CSR_MCYCLEH:   rd_data = mcycle[63:32];
            CSR_MINSTRETH: rd_data = minstret[63:32];
`endif
            default:       rd_resp = RRESP_ILLEGAL;
        endcase
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            RD_IDLE: if (csrbus_arvalid) begin
                accept  = 1'b1;
                state_d = RD_RESP;
            end
            RD_RESP: state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RD_IDLE;
            rdata_q <= '0;
            rresp_q <= RRESP_OKAY;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rdata_q <= rd_data;
                rresp_q <= rd_resp;
            end
        end
    end

    // Bus outputs are forced quiet while reset is held, so a response in flight is dropped.
    assign csrbus_rvalid = reset_n && (state_q == RD_RESP);
    assign csrbus_rdata  = reset_n ? rdata_q : '0;
    assign csrbus_rresp  = reset_n ? rresp_q : RRESP_OKAY;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mtvec_q    <= MTVEC_RESET;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mscratch_q <= '0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
        end else begin
            if (wr_hit(CSR_MTVEC))    mtvec_q    <= csr_write_val & ~32'h3;
            if (wr_hit(CSR_MSCRATCH)) mscratch_q <= csr_write_val;

            // Trap beats mret beats a software write on the trap-owned registers.
            if (trap_valid) begin
                mepc_q   <= trap_pc & ~32'h3;
                mcause_q <= trap_cause;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else begin
                if (wr_hit(CSR_MEPC))   mepc_q   <= csr_write_val & ~32'h3;
                if (wr_hit(CSR_MCAUSE)) mcause_q <= csr_write_val;
                if (mret_valid) begin
                    mie_q  <= mpie_q;
                    mpie_q <= 1'b1;
                end else if (wr_hit(CSR_MSTATUS)) begin
                    mie_q  <= csr_write_val[MSTATUS_MIE];
                    mpie_q <= csr_write_val[MSTATUS_MPIE];
                end
            end
        end
    end

    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;
    assign mie_out   = mie_q;

endmodule
